apb_master_bridge: RTL and testbench
====================================

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, the APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, the APB data width; legal values are 8, 16 and 32; STRB_W = DATA_W/8.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 16, the ACCESS-phase cycle limit (range 1..65535).
REQ-004 SHALL have ports:
- pclk  in  1  sole clock; all logic is sampled on its rising edge.
- preset  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  STRB_W  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data.
- rsp_err  out  1  slave error or timeout.
- paddr, psel, penable, pwrite, pstrb, pwdata  out  APB request signals.
- prdata, pready, pslverr  in  APB completion signals.

Function
REQ-005 SHALL implement the FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
REQ-006 SHALL drive cmd_ready=1 only in IDLE; a handshake in cycle N registers the command and enters SETUP at N+1.
REQ-007 In SETUP: psel=1, penable=0, and paddr/pwrite/pwdata/pstrb driven from the registered command; SHALL move to ACCESS after exactly one cycle.
REQ-008 In ACCESS: psel=1, penable=1, all APB request signals held stable; SHALL stay in ACCESS while pready=0.
REQ-009 On pready=1 in ACCESS, SHALL capture prdata (reads) and pslverr, deassert psel and penable at the next edge, and enter RESP.
REQ-010 Minimum latency: with pready=1 on first ACCESS cycle, rsp_valid SHALL assert at N+3.
REQ-011 SHALL drive pstrb=0 for reads and cmd_strb for writes; pwdata SHALL be 0 for reads.
REQ-012 For writes, SHALL drive rsp_rdata=0; for reads, rsp_rdata SHALL be the full prdata, with no strobe masking.
REQ-013 In RESP: rsp_valid=1, with rsp_rdata/rsp_err held until rsp_ready=1; then SHALL return to IDLE, with cmd_ready=1 in the following cycle.
REQ-014 pslverr SHALL be sampled only in the completing ACCESS cycle and otherwise ignored.
REQ-015 psel SHALL be 0 in IDLE and RESP; back-to-back transfers SHALL have at least one psel-low cycle between them.

Reset
REQ-016 While preset=1, SHALL force state to IDLE and drive every output to 0 (cmd_ready=0), at the next pclk edge.
REQ-017 A reset during SETUP, ACCESS or RESP SHALL abort the transfer, discard any pending response, and produce no rsp_valid after release.
REQ-018 cmd_ready SHALL become 1 on the first cycle after preset falls.

Configuration
REQ-019 With APB_MASTER_TIMEOUT_EN defined, a cycle counter SHALL run in ACCESS. If pready stays 0 for TIMEOUT_CYC consecutive ACCESS cycles, the bridge SHALL drop psel and penable, enter RESP with rsp_err=1 and rsp_rdata=0, and clear the counter on every ACCESS entry.
REQ-020 Without APB_MASTER_TIMEOUT_EN, the bridge SHALL contain no counter logic and SHALL wait in ACCESS indefinitely.

Structure
REQ-021 Package apb_pkg SHALL hold the FSM state enum (IDLE, SETUP, ACCESS, RESP) and the default width constants shared with the APB UVC.
REQ-022 The design SHALL be a single module with no sub-modules; the timeout counter is inline under the macro.

Verification
REQ-023 Write 0x010, data 0xDEADBEEF, strb 0xF, pready=1 immediately -> setup/access on N+1/N+2, rsp_valid at N+3, rsp_err=0.
REQ-024 Read 0x020 with 3 wait states, prdata=0x12345678 -> penable high for 4 cycles, rsp_rdata=0x12345678.
REQ-025 Write with strb 0x5, slave returns pslverr=1 -> pstrb=0x5 on bus, rsp_err=1, rsp_rdata=0.
REQ-026 rsp_ready held low 5 cycles -> rsp_valid/rsp_rdata stable, cmd_ready=0, no new psel.
REQ-027 With the macro on and pready stuck at 0 -> after 16 ACCESS cycles psel=0, rsp_err=1; with the macro off -> still in ACCESS after 1000 cycles.
REQ-028 preset pulsed during ACCESS -> all outputs 0 next cycle, no rsp_valid after release, cmd_ready=1 the cycle after preset falls.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions for the master bridge and the APB UVC.
//   APB_ADDR_W  - default APB address width
//   APB_DATA_W  - default APB data width (8, 16 or 32)
//   apb_state_e - bridge FSM states
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 12;
    localparam int unsigned APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response and APB bus bundle for apb_master_bridge.
//   master modport : bridge side (takes commands, drives APB requests, returns responses)
//   slave modport  : environment side (issues commands, models the APB slave)
// Command:  cmd_valid, cmd_ready, cmd_write, cmd_addr, cmd_wdata, cmd_strb
// Response: rsp_valid, rsp_ready, rsp_rdata, rsp_err
// APB:      paddr, psel, penable, pwrite, pstrb, pwdata, prdata, pready, pslverr
interface apb_master_bridge_if #(
    parameter int unsigned ADDR_W = apb_pkg::APB_ADDR_W,
    parameter int unsigned DATA_W = apb_pkg::APB_DATA_W
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_strb;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [STRB_W-1:0] pstrb;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output paddr, psel, penable, pwrite, pstrb, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  paddr, psel, penable, pwrite, pstrb, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_master_bridge.sv
// Single-command APB master bridge: accepts one command, runs one APB transfer
// (SETUP then ACCESS until pready), and holds the response until consumed.
// Ports:
//   pclk   - sole clock, rising edge
//   preset - synchronous active-high reset; aborts any transfer in flight
//   bus    - apb_master_bridge_if.master (command, response and APB signals)
// Parameters: ADDR_W, DATA_W (8/16/32), TIMEOUT_CYC (1..65535).
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort an ACCESS phase that
// sees no pready for TIMEOUT_CYC cycles (response then carries rsp_err=1).
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W      = APB_ADDR_W,
    parameter int unsigned DATA_W      = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input logic             pclk,
    input logic             preset,
    apb_master_bridge_if.master bus
);

    localparam int unsigned STRB_W = DATA_W / 8;

    if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32)) begin : g_bad_data_w
        $error("apb_master_bridge: DATA_W must be 8, 16 or 32");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("apb_master_bridge: TIMEOUT_CYC must be 1..65535");
    end

    apb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] strb_q,  strb_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q,   err_d;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = 16;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_d = SETUP;
                    addr_d  = bus.cmd_addr;
                    write_d = bus.cmd_write;
                    // Reads put zeros on pwdata/pstrb.
                    wdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
                    strb_d  = bus.cmd_write ? bus.cmd_strb  : '0;
                end
            end
            SETUP: begin
                state_d = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ACCESS: begin
                // pslverr only matters on the completing cycle.
                if (bus.pready) begin
                    state_d = RESP;
                    rdata_d = write_q ? '0 : bus.prdata;
                    err_d   = bus.pslverr;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Gating with preset keeps cmd_ready low while reset is held even though
    // the state register already reads IDLE.
    assign bus.cmd_ready = (state_q == IDLE) && !preset;
    assign bus.psel      = (state_q == SETUP) || (state_q == ACCESS);
    assign bus.penable   = (state_q == ACCESS);
    assign bus.paddr     = addr_q;
    assign bus.pwrite    = write_q;
    assign bus.pwdata    = wdata_q;
    assign bus.pstrb     = strb_q;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: scoreboard of expected responses,
// behavioural APB slave with programmable wait states / error / stall.
module tb_apb_master_bridge;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic pclk   = 1'b0;
    logic preset = 1'b1;

    apb_master_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

    apb_master_bridge #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (16)
    ) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus_if)
    );

    always #5 pclk = ~pclk;

    int   n_vec = 0;
    int   n_err = 0;
    rsp_t exp_q[$];

    // Slave behaviour settings
    int          slv_ws    = 0;
    bit          slv_stuck = 1'b0;
    logic [31:0] slv_rdata = 32'h0;
    logic        slv_err   = 1'b0;
    int          slv_cnt   = 0;

    // Values driven in SETUP, expected stable through ACCESS
    logic [11:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_strb;
    logic        cur_wr;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Slave updates 1 time unit after the edge so setting changes made on the
    // falling edge never race it.
    always @(posedge pclk) begin
        #1;
        if (bus_if.psel === 1'b1 && bus_if.penable === 1'b1) begin
            if (!slv_stuck && slv_cnt >= slv_ws) begin
                bus_if.pready  = 1'b1;
                bus_if.prdata  = slv_rdata;
                bus_if.pslverr = slv_err;
            end else begin
                bus_if.pready  = 1'b0;
                bus_if.prdata  = 32'hBAD0_BAD0;
                bus_if.pslverr = 1'b1;
                slv_cnt++;
            end
        end else begin
            bus_if.pready  = 1'b0;
            bus_if.prdata  = 32'hBAD1_BAD1;
            bus_if.pslverr = 1'b1;
            slv_cnt        = 0;
        end
    end

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_cmd_ready"}, 32'(bus_if.cmd_ready), 32'd0);
        check_eq({pfx, "_psel"},      32'(bus_if.psel),      32'd0);
        check_eq({pfx, "_penable"},   32'(bus_if.penable),   32'd0);
        check_eq({pfx, "_pwrite"},    32'(bus_if.pwrite),    32'd0);
        check_eq({pfx, "_paddr"},     32'(bus_if.paddr),     32'd0);
        check_eq({pfx, "_pwdata"},    bus_if.pwdata,         32'd0);
        check_eq({pfx, "_pstrb"},     32'(bus_if.pstrb),     32'd0);
        check_eq({pfx, "_rsp_valid"}, 32'(bus_if.rsp_valid), 32'd0);
        check_eq({pfx, "_rsp_rdata"}, bus_if.rsp_rdata,      32'd0);
        check_eq({pfx, "_rsp_err"},   32'(bus_if.rsp_err),   32'd0);
    endtask

    // Called on a falling edge with the bridge idle. Returns on the SETUP cycle.
    task automatic issue(input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                         input logic [3:0] strb, input rsp_t exp);
        int guard = 0;
        bus_if.cmd_write = wr;
        bus_if.cmd_addr  = addr;
        bus_if.cmd_wdata = wd;
        bus_if.cmd_strb  = strb;
        bus_if.cmd_valid = 1'b1;
        while (bus_if.cmd_ready !== 1'b1 && guard < 50) begin
            @(negedge pclk);
            guard++;
        end
        check_eq("cmd_ready_wait", 32'(guard), 32'd0);
        exp_q.push_back(exp);
        cur_wr    = wr;
        cur_addr  = addr;
        cur_wdata = wr ? wd : 32'h0;
        cur_strb  = wr ? strb : 4'h0;
        @(negedge pclk);
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_addr  = ~addr;
        bus_if.cmd_wdata = ~wd;
        bus_if.cmd_strb  = ~strb;
        check_eq("setup_psel",    32'(bus_if.psel),      32'd1);
        check_eq("setup_penable", 32'(bus_if.penable),   32'd0);
        check_eq("setup_cmd_rdy", 32'(bus_if.cmd_ready), 32'd0);
        check_eq("setup_paddr",   32'(bus_if.paddr),     32'(cur_addr));
        check_eq("setup_pwrite",  32'(bus_if.pwrite),    32'(cur_wr));
        check_eq("setup_pwdata",  bus_if.pwdata,         cur_wdata);
        check_eq("setup_pstrb",   32'(bus_if.pstrb),     32'(cur_strb));
    endtask

    // Counts ACCESS cycles (psel high) up to limit, checking bus stability.
    task automatic run_access(input int limit, output int n);
        n = 0;
        @(negedge pclk);
        while (bus_if.psel === 1'b1 && n < limit) begin
            check_eq("acc_penable", 32'(bus_if.penable), 32'd1);
            check_eq("acc_paddr",   32'(bus_if.paddr),   32'(cur_addr));
            check_eq("acc_pwrite",  32'(bus_if.pwrite),  32'(cur_wr));
            check_eq("acc_pwdata",  bus_if.pwdata,       cur_wdata);
            check_eq("acc_pstrb",   32'(bus_if.pstrb),   32'(cur_strb));
            n++;
            @(negedge pclk);
        end
    endtask

    // Holds rsp_ready low for 'hold' cycles, then consumes the response.
    task automatic take_rsp(input int hold);
        rsp_t exp;
        check_eq("sb_level", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) exp = exp_q[0];
        else                  exp = '0;
        repeat (hold) begin
            check_eq("hold_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
            check_eq("hold_rsp_rdata", bus_if.rsp_rdata,      exp.rdata);
            check_eq("hold_rsp_err",   32'(bus_if.rsp_err),   32'(exp.err));
            check_eq("hold_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
            check_eq("hold_psel",      32'(bus_if.psel),      32'd0);
            @(negedge pclk);
        end
        check_eq("rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
        check_eq("rsp_rdata", bus_if.rsp_rdata,      exp.rdata);
        check_eq("rsp_err",   32'(bus_if.rsp_err),   32'(exp.err));
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        bus_if.rsp_ready = 1'b1;
        @(negedge pclk);
        bus_if.rsp_ready = 1'b0;
        check_eq("post_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        check_eq("post_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
        check_eq("post_psel",      32'(bus_if.psel),      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_write = 1'b0;
        bus_if.cmd_addr  = '0;
        bus_if.cmd_wdata = '0;
        bus_if.cmd_strb  = '0;
        bus_if.rsp_ready = 1'b0;
        bus_if.pready    = 1'b0;
        bus_if.prdata    = '0;
        bus_if.pslverr   = 1'b0;

        // Reset state
        repeat (3) @(negedge pclk);
        check_all_zero("rst");
        preset = 1'b0;
        @(negedge pclk);
        check_eq("rel_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);

        // Write, zero wait states: SETUP N+1, ACCESS N+2, rsp_valid N+3
        slv_ws = 0; slv_rdata = 32'hCAFE_F00D; slv_err = 1'b0;
        issue(1'b1, 12'h010, 32'hDEAD_BEEF, 4'hF, '{rdata: 32'h0, err: 1'b0});
        run_access(50, n);
        check_eq("wr0_acc_cycles", 32'(n), 32'd1);
        take_rsp(0);

        // Read with 3 wait states
        slv_ws = 3; slv_rdata = 32'h1234_5678; slv_err = 1'b0;
        issue(1'b0, 12'h020, 32'hFFFF_FFFF, 4'hF, '{rdata: 32'h1234_5678, err: 1'b0});
        run_access(50, n);
        check_eq("rd3_acc_cycles", 32'(n), 32'd4);
        take_rsp(0);

        // Partial-strobe write with slave error
        slv_ws = 1; slv_rdata = 32'h5555_AAAA; slv_err = 1'b1;
        issue(1'b1, 12'h03C, 32'hA5A5_A5A5, 4'h5, '{rdata: 32'h0, err: 1'b1});
        run_access(50, n);
        check_eq("wrerr_acc_cycles", 32'(n), 32'd2);
        take_rsp(0);

        // Read with rsp_ready held low for 5 cycles
        slv_ws = 0; slv_rdata = 32'h0BAD_F00D; slv_err = 1'b0;
        issue(1'b0, 12'h044, 32'h0, 4'h0, '{rdata: 32'h0BAD_F00D, err: 1'b0});
        run_access(50, n);
        check_eq("hold_acc_cycles", 32'(n), 32'd1);
        take_rsp(5);

        // Read with slave error still returns full prdata
        slv_ws = 2; slv_rdata = 32'h8765_4321; slv_err = 1'b1;
        issue(1'b0, 12'h800, 32'h0, 4'h3, '{rdata: 32'h8765_4321, err: 1'b1});
        run_access(50, n);
        check_eq("rderr_acc_cycles", 32'(n), 32'd3);
        take_rsp(0);

        // Stalled slave
        slv_stuck = 1'b1; slv_ws = 0; slv_err = 1'b0; slv_rdata = 32'h600D_CAFE;
`ifdef APB_MASTER_TIMEOUT_EN
        issue(1'b0, 12'h0FF, 32'h0, 4'h0, '{rdata: 32'h0, err: 1'b1});
        run_access(100, n);
        check_eq("to_acc_cycles", 32'(n), 32'd16);
        check_eq("to_psel",       32'(bus_if.psel), 32'd0);
        take_rsp(0);
        slv_stuck = 1'b0;
`else
        issue(1'b0, 12'h0FF, 32'h0, 4'h0, '{rdata: 32'h600D_CAFE, err: 1'b0});
        run_access(1000, n);
        check_eq("stall_acc_cycles", 32'(n), 32'd1000);
        check_eq("stall_psel",       32'(bus_if.psel),      32'd1);
        check_eq("stall_penable",    32'(bus_if.penable),   32'd1);
        check_eq("stall_rsp_valid",  32'(bus_if.rsp_valid), 32'd0);
        slv_stuck = 1'b0;
        run_access(10, n);
        check_eq("unstall_acc_cycles", 32'(n), 32'd1);
        take_rsp(0);
`endif

        // Reset pulsed during ACCESS
        slv_ws = 10; slv_rdata = 32'h1111_2222; slv_err = 1'b0;
        issue(1'b1, 12'h0AA, 32'h3333_4444, 4'hA, '{rdata: 32'h0, err: 1'b0});
        repeat (3) @(negedge pclk);
        check_eq("pre_rst_penable", 32'(bus_if.penable), 32'd1);
        preset = 1'b1;
        @(negedge pclk);
        check_all_zero("mid_rst");
        exp_q.delete();
        preset = 1'b0;
        @(negedge pclk);
        check_eq("after_rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
        repeat (12) begin
            check_eq("after_rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
            check_eq("after_rst_psel",      32'(bus_if.psel),      32'd0);
            @(negedge pclk);
        end

        // Normal operation resumes
        slv_ws = 0; slv_rdata = 32'h7777_7777; slv_err = 1'b0;
        issue(1'b1, 12'h7FC, 32'h0102_0304, 4'hC, '{rdata: 32'h0, err: 1'b0});
        run_access(50, n);
        check_eq("last_acc_cycles", 32'(n), 32'd1);
        take_rsp(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
